// File: rtl/demux32_buf.sv
// demux32_buf: registered 1-to-8 distributor for data words.
// A producer word is steered by Sel into one of eight single-entry holding
// slots. Each slot is drained on its own by a valid/ack handshake. A slot
// can be acked and reloaded in the same cycle, so each slot can move one
// word per cycle.
module demux32_buf #(
   parameter int WIDTH = 32,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] In,
   input  logic [2:0]       Sel,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] Out0,
   output logic [WIDTH-1:0] Out1,
   output logic [WIDTH-1:0] Out2,
   output logic [WIDTH-1:0] Out3,
   output logic [WIDTH-1:0] Out4,
   output logic [WIDTH-1:0] Out5,
   output logic [WIDTH-1:0] Out6,
   output logic [WIDTH-1:0] Out7,
   output logic [7:0]       OutValid,
   input  logic [7:0]       OutAck,
   output logic [CNTW-1:0]  XferCount
);

   logic [WIDTH-1:0] data_r [8];
   logic [7:0]       valid_r;
   logic [CNTW-1:0]  count_r;

   logic [7:0]       sel_onehot_s;
   logic             ready_s;
   logic             accept_s;
   logic [7:0]       load_s;
   logic [7:0]       drain_s;

   // Readiness of the addressed slot, accept decision and per-slot load/drain masks.
   always_comb begin
      sel_onehot_s = 8'h01 << Sel;
      ready_s      = ~valid_r[Sel] | OutAck[Sel];
      accept_s     = InValid & ready_s & ~reset;
      if (accept_s) begin
         load_s = sel_onehot_s;
      end else begin
         load_s = 8'h00;
      end
      // A slot being reloaded this cycle stays valid even if it is also acked.
      drain_s = OutAck & valid_r & ~load_s;
   end

   // Slot data, slot valid flags and the accepted-word counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            data_r[i] <= {WIDTH{1'b0}};
         end
         valid_r <= 8'h00;
         count_r <= {CNTW{1'b0}};
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (load_s[i]) begin
               data_r[i] <= In;
            end else begin
               data_r[i] <= data_r[i];
            end
         end
         valid_r <= (valid_r & ~drain_s) | load_s;
         if (accept_s) begin
            count_r <= count_r + {{(CNTW-1){1'b0}}, 1'b1};
         end else begin
            count_r <= count_r;
         end
      end
   end

   assign InReady   = ready_s;
   assign Out0      = data_r[0];
   assign Out1      = data_r[1];
   assign Out2      = data_r[2];
   assign Out3      = data_r[3];
   assign Out4      = data_r[4];
   assign Out5      = data_r[5];
   assign Out6      = data_r[6];
   assign Out7      = data_r[7];
   assign OutValid  = valid_r;
   assign XferCount = count_r;

endmodule

// File: tb/tb_demux32_buf.sv
// Bench for demux32_buf: directed vectors, a slot-level reference model and
// a per-cycle compare of every output against that model, plus literal pins.
module tb_demux32_buf;

   logic        clk;
   logic        reset;
   logic [31:0] In;
   logic [2:0]  Sel;
   logic        InValid;
   logic        InReady;
   logic [31:0] Out0, Out1, Out2, Out3, Out4, Out5, Out6, Out7;
   logic [7:0]  OutValid;
   logic [7:0]  OutAck;
   logic [7:0]  XferCount;

   logic [31:0] outs [8];
   assign outs[0] = Out0;
   assign outs[1] = Out1;
   assign outs[2] = Out2;
   assign outs[3] = Out3;
   assign outs[4] = Out4;
   assign outs[5] = Out5;
   assign outs[6] = Out6;
   assign outs[7] = Out7;

   demux32_buf #(.WIDTH(32), .CNTW(8)) dut (
      .clk(clk), .reset(reset), .In(In), .Sel(Sel), .InValid(InValid),
      .InReady(InReady),
      .Out0(Out0), .Out1(Out1), .Out2(Out2), .Out3(Out3),
      .Out4(Out4), .Out5(Out5), .Out6(Out6), .Out7(Out7),
      .OutValid(OutValid), .OutAck(OutAck), .XferCount(XferCount)
   );

   // reference model: what each slot holds, whether it is full, and words accepted
   logic [31:0] m_data [8];
   bit          m_full [8];
   int          m_count;
   bit          chk_en;

   int total;
   int bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model_valid();
      logic [7:0] v;
      for (int i = 0; i < 8; i++) v[i] = m_full[i];
      return v;
   endfunction

   // one cycle: drive inputs, check readiness, advance the model at the clock edge
   task automatic step(input logic [31:0] d, input logic [2:0] s, input logic v,
                       input logic [7:0] ack, input logic r);
      bit exp_ready;
      bit acc;
      In = d; Sel = s; InValid = v; OutAck = ack; reset = r;
      #1;
      exp_ready = !m_full[s] || ack[s];
      if (chk_en) chk("inready", {63'd0, InReady}, {63'd0, exp_ready});
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 8; i++) begin
            m_data[i] = 32'd0;
            m_full[i] = 1'b0;
         end
         m_count = 0;
      end else begin
         acc = v && exp_ready;
         for (int i = 0; i < 8; i++) begin
            if (ack[i]) m_full[i] = 1'b0;
         end
         if (acc) begin
            m_data[s] = d;
            m_full[s] = 1'b1;
            m_count   = (m_count + 1) % 256;
         end
      end
      #2;
   endtask

   // compare every output against the model each cycle once reset has been applied
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("out%0d", i), {32'd0, outs[i]}, {32'd0, m_data[i]});
         end
         chk("outvalid", {56'd0, OutValid}, {56'd0, model_valid()});
         chk("xfercount", {56'd0, XferCount}, 64'(m_count));
      end
   end

   initial begin
      total = 0; bad = 0; chk_en = 1'b0;
      m_count = 0;
      for (int i = 0; i < 8; i++) begin
         m_data[i] = 32'd0;
         m_full[i] = 1'b0;
      end
      In = 32'd0; Sel = 3'd0; InValid = 1'b0; OutAck = 8'h00; reset = 1'b1;
      @(posedge clk); #2;

      step(32'd0, 3'd0, 1'b0, 8'h00, 1'b1);
      chk_en = 1'b1;
      step(32'd0, 3'd0, 1'b0, 8'h00, 1'b1);
      chk("rst_valid", {56'd0, OutValid}, 64'h00);
      chk("rst_count", {56'd0, XferCount}, 64'd0);
      chk("rst_out3", {32'd0, Out3}, 64'd0);

      // single write to slot 3
      step(32'hDEADBEEF, 3'd3, 1'b1, 8'h00, 1'b0);
      chk("w1_out3", {32'd0, Out3}, 64'hDEADBEEF);
      chk("w1_valid", {56'd0, OutValid}, 64'h08);
      chk("w1_count", {56'd0, XferCount}, 64'd1);

      // full slot, no ack: refused
      In = 32'h1234; Sel = 3'd3; InValid = 1'b1; OutAck = 8'h00; #1;
      chk("full_ready", {63'd0, InReady}, 64'd0);
      step(32'h1234, 3'd3, 1'b1, 8'h00, 1'b0);
      chk("full_out3", {32'd0, Out3}, 64'hDEADBEEF);
      chk("full_count", {56'd0, XferCount}, 64'd1);

      // ack and accept together on slot 3
      In = 32'hCAFE0000; OutAck = 8'h08; #1;
      chk("ackacc_ready", {63'd0, InReady}, 64'd1);
      step(32'hCAFE0000, 3'd3, 1'b1, 8'h08, 1'b0);
      chk("ackacc_out3", {32'd0, Out3}, 64'hCAFE0000);
      chk("ackacc_valid", {56'd0, OutValid}, 64'h08);
      chk("ackacc_count", {56'd0, XferCount}, 64'd2);

      // drain slot 3, data held
      step(32'd0, 3'd0, 1'b0, 8'h08, 1'b0);
      chk("drain_valid", {56'd0, OutValid}, 64'h00);
      chk("drain_out3", {32'd0, Out3}, 64'hCAFE0000);

      // back-to-back fill of all slots, then ack all
      for (int i = 0; i < 8; i++) begin
         step(32'(i) * 32'h11111111, 3'(i), 1'b1, 8'h00, 1'b0);
      end
      chk("fill_valid", {56'd0, OutValid}, 64'hFF);
      chk("fill_count", {56'd0, XferCount}, 64'd10);
      step(32'd0, 3'd0, 1'b0, 8'hFF, 1'b0);
      chk("ackall_valid", {56'd0, OutValid}, 64'h00);
      chk("ackall_out5", {32'd0, Out5}, 64'h55555555);

      // 256 accepts into slot 0 at full rate from a fresh reset
      step(32'd0, 3'd0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 256; i++) begin
         step(32'(i), 3'd0, 1'b1, 8'h01, 1'b0);
         if (i == 254) chk("wrap_pre", {56'd0, XferCount}, 64'hFF);
      end
      chk("wrap_count", {56'd0, XferCount}, 64'd0);
      chk("wrap_out0", {32'd0, Out0}, 64'd255);
      step(32'd0, 3'd0, 1'b0, 8'h10, 1'b0);
      chk("ackempty_valid", {56'd0, OutValid}, 64'h01);
      chk("ackempty_count", {56'd0, XferCount}, 64'd0);

      // other-slot drain concurrent with an accept elsewhere
      step(32'hA5A5A5A5, 3'd2, 1'b1, 8'h01, 1'b0);
      chk("indep_valid", {56'd0, OutValid}, 64'h04);

      // reset with a pending offer
      step(32'h66666666, 3'd6, 1'b1, 8'h00, 1'b0);
      step(32'hAAAAAAAA, 3'd1, 1'b1, 8'h00, 1'b1);
      chk("rst2_valid", {56'd0, OutValid}, 64'h00);
      chk("rst2_count", {56'd0, XferCount}, 64'd0);
      chk("rst2_out1", {32'd0, Out1}, 64'd0);
      chk("rst2_out2", {32'd0, Out2}, 64'd0);
      chk("rst2_out6", {32'd0, Out6}, 64'd0);

      step(32'd0, 3'd0, 1'b0, 8'h00, 1'b0);
      @(negedge clk); #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
